rgmii_rx_framer: RTL and testbench
==================================

RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME_BYTES, default 1522: largest accepted payload, counted from the first byte after SFD.
REQ-002 SHALL have parameter MIN_FRAME_BYTES, default 64: smallest payload accepted without error.
REQ-003 SHALL have clock  input  1: the single clock, rising edge only.
REQ-004 SHALL have reset_n  input  1: reset, synchronous and active-low.
REQ-005 SHALL have ddr_data_input  input  8: captured RGMII RXD. [7:4] is the rising-edge nibble (byte bits 3:0); [3:0] is the falling-edge nibble (byte bits 7:4).
REQ-006 SHALL have ddr_control_input  input  2: captured RX_CTL. [1] is the rising-edge sample (rx_dv); [0] is the falling-edge sample (rx_dv XOR rx_er).
REQ-007 SHALL have data_output  output  8: payload byte.
REQ-008 SHALL have data_valid  output  1: data_output is valid this cycle.
REQ-009 SHALL have data_last  output  1: final byte of the frame; qualified by data_valid.
REQ-010 SHALL have data_error  output  1: frame is bad; qualified by data_valid and data_last.
REQ-011 SHALL have frame_count  output  16: count of good frames.
REQ-012 SHALL have error_count  output  16: count of bad or dropped frames.

Function
REQ-013 SHALL decode each cycle: byte = {ddr_data_input[3:0], ddr_data_input[7:4]}; rx_dv = ddr_control_input[1]; rx_er = ddr_control_input[1] ^ ddr_control_input[0].
REQ-014 SHALL register all inputs once before any decode.
REQ-015 SHALL implement the FSM states IDLE, PREAMBLE, PAYLOAD and DROP.
REQ-016 IDLE SHALL transition on rx_dv=1 as follows: byte 0x55 -> PREAMBLE; byte 0xD5 -> PAYLOAD; any other byte, or rx_er=1 -> DROP. With rx_dv=0, IDLE SHALL ignore all control and data (in-band status).
REQ-017 PREAMBLE SHALL transition as follows: 0x55 -> stay; 0xD5 -> PAYLOAD; other byte or rx_er=1 -> DROP; rx_dv=0 -> IDLE with error_count increment.
REQ-018 PAYLOAD SHALL forward every rx_dv=1 byte in order, including bytes with rx_er=1, and SHALL set a sticky frame-error flag on any rx_er=1.
REQ-019 DROP SHALL discard bytes until rx_dv=0, then go to IDLE.
REQ-020 SHALL increment error_count exactly once on each entry to DROP from IDLE or PREAMBLE.
REQ-021 SHALL use a one-byte hold stage so that data_last is known when a byte is emitted.
REQ-022 Latency: a payload byte present on the inputs in cycle i SHALL appear with data_valid=1 in cycle i+3.
REQ-023 SHALL assert data_last on payload byte i when rx_dv=0 in cycle i+1.
REQ-024 data_valid SHALL be a single-cycle pulse per byte; consecutive bytes SHALL produce consecutive pulses with no gaps.
REQ-025 On data_last, data_error SHALL be 1 if any of the following holds: sticky rx_er set; payload length < MIN_FRAME_BYTES.
REQ-026 Oversize: if byte number MAX_FRAME_BYTES is followed by rx_dv=1, that byte SHALL be emitted with data_last=1 and data_error=1, and the FSM SHALL go to DROP without an additional error_count increment.
REQ-027 A payload of exactly MAX_FRAME_BYTES SHALL end normally, with no error from length.
REQ-028 SFD followed immediately by rx_dv=0 (zero payload bytes) SHALL emit nothing, SHALL increment error_count, and SHALL return the FSM to IDLE.
REQ-029 Counters: frame_count SHALL increment on each data_last with data_error=0; error_count SHALL increment on each data_last with data_error=1. Both SHALL saturate at 0xFFFF.
REQ-030 When the error counter event and a DROP-entry event coincide in one cycle, error_count SHALL increment by 1 only.
REQ-031 The byte length counter SHALL saturate at MAX_FRAME_BYTES+1 and SHALL never wrap.

Reset
REQ-032 When reset_n=0 at a rising clock edge, all of the following SHALL clear: FSM to IDLE; hold stage, length counter and sticky flag; data_output=0x00; data_valid=0; data_last=0; data_error=0; frame_count=0; error_count=0.
REQ-033 Reset mid-frame SHALL abandon the frame with no data_last emitted. After reset_n returns high, the first rx_dv=1 byte SHALL be decoded per REQ-016.

Verification
REQ-034 Good frame: 7x 0x55, 0xD5, 64 bytes 0x00..0x3F, then rx_dv=0 -> 64 consecutive data_valid pulses with bytes 0x00..0x3F; data_last on 0x3F; data_error=0; frame_count=1.
REQ-035 Nibble order: ddr_data_input=0x21 during payload -> data_output=0x12.
REQ-036 rx_er mid-payload (ddr_control_input=2'b10 on byte 10 of 64) -> all 64 bytes emitted; data_last with data_error=1; error_count=1; frame_count=0.
REQ-037 Runt and zero-length: 20-byte payload -> data_last with data_error=1; SFD then rx_dv=0 -> no data_valid; error_count=2.
REQ-038 Oversize with MAX_FRAME_BYTES=100: 150-byte payload -> 100 pulses, the 100th with data_last=1 and data_error=1; the remaining 50 bytes dropped; the next good frame is received normally.
REQ-039 Bad preamble and reset: 0x55, 0x55, 0xAA, ... -> DROP and error_count +1, no output; reset_n=0 for one cycle mid-payload -> all outputs and counters 0, no data_last emitted.

Source files
------------

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: registers DDR samples, strips preamble/SFD and emits payload
// bytes with end-of-frame and error flags, plus saturating good/bad frame counters.
module rgmii_rx_framer #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int MIN_FRAME_BYTES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  ddr_data_input,
  input  logic [1:0]  ddr_control_input,
  output logic [7:0]  data_output,
  output logic        data_valid,
  output logic        data_last,
  output logic        data_error,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
);

  localparam int LW = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_FRAME_BYTES);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_FRAME_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    DROP     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    rxd_q;
  logic [1:0]    rxc_q;
  logic [7:0]    hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [LW-1:0] len_q, len_d;
  logic          sticky_q, sticky_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          error_q, error_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic [7:0]    byte_s;
  logic          dv_s, er_s;
  logic          emit_s, emit_last_s, emit_err_s, lost_evt_s;

  // Rising-edge nibble carries byte bits 3:0, falling-edge nibble carries bits 7:4.
  assign byte_s = {rxd_q[3:0], rxd_q[7:4]};
  assign dv_s   = rxc_q[1];
  assign er_s   = rxc_q[1] ^ rxc_q[0];

  // Frame state machine; the hold stage delays each payload byte one cycle so the
  // following rx_dv sample decides whether it is the last one.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_vld_d  = 1'b0;
    len_d       = '0;
    sticky_d    = 1'b0;
    emit_s      = 1'b0;
    emit_last_s = 1'b0;
    emit_err_s  = 1'b0;
    lost_evt_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!dv_s) begin
          state_d = IDLE;
        end else if (er_s) begin
          state_d    = DROP;
          lost_evt_s = 1'b1;
        end else if (byte_s == 8'h55) begin
          state_d = PREAMBLE;
        end else if (byte_s == 8'hD5) begin
          state_d = PAYLOAD;
        end else begin
          state_d    = DROP;
          lost_evt_s = 1'b1;
        end
      end
      PREAMBLE: begin
        if (!dv_s) begin
          state_d    = IDLE;
          lost_evt_s = 1'b1;
        end else if (!er_s && byte_s == 8'h55) begin
          state_d = PREAMBLE;
        end else if (!er_s && byte_s == 8'hD5) begin
          state_d = PAYLOAD;
        end else begin
          state_d    = DROP;
          lost_evt_s = 1'b1;
        end
      end
      PAYLOAD: begin
        if (!dv_s) begin
          state_d = IDLE;
          if (hold_vld_q) begin
            emit_s      = 1'b1;
            emit_last_s = 1'b1;
            emit_err_s  = sticky_q || (int'(len_q) < MIN_FRAME_BYTES);
          end else begin
            lost_evt_s = 1'b1;
          end
        end else if (len_q == LEN_MAX) begin
          // Oversize: close the frame on the held byte and swallow the rest.
          state_d     = DROP;
          emit_s      = 1'b1;
          emit_last_s = 1'b1;
          emit_err_s  = 1'b1;
        end else begin
          emit_s     = hold_vld_q;
          hold_d     = byte_s;
          hold_vld_d = 1'b1;
          len_d      = (len_q == LEN_SAT) ? len_q : len_q + LW'(1);
          sticky_d   = sticky_q | er_s;
        end
      end
      DROP: begin
        if (!dv_s) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register inputs and saturating counters.
  always_comb begin
    dout_d      = emit_s ? hold_q : 8'h00;
    valid_d     = emit_s;
    last_d      = emit_last_s;
    error_d     = emit_err_s;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (emit_last_s && !emit_err_s && frame_cnt_q != 16'hFFFF) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (((emit_last_s && emit_err_s) || lost_evt_s) && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rxd_q       <= 8'h00;
      rxc_q       <= 2'b00;
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_vld_q  <= 1'b0;
      len_q       <= '0;
      sticky_q    <= 1'b0;
      dout_q      <= 8'h00;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      error_q     <= 1'b0;
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      rxd_q       <= ddr_data_input;
      rxc_q       <= ddr_control_input;
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      len_q       <= len_d;
      sticky_q    <= sticky_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      error_q     <= error_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_output = dout_q;
  assign data_valid  = valid_q;
  assign data_last   = last_q;
  assign data_error  = error_q;
  assign frame_count = frame_cnt_q;
  assign error_count = err_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Bench for rgmii_rx_framer: directed and random bursts scored against a per-frame
// reference model that classifies each rx_dv burst as a whole.
module tb_rgmii_rx_framer;

  localparam int MAXB = 100;
  localparam int MINB = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  ddr_data_input;
  logic [1:0]  ddr_control_input;
  logic [7:0]  data_output;
  logic        data_valid;
  logic        data_last;
  logic        data_error;
  logic [15:0] frame_count;
  logic [15:0] error_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_frm  = 0;
  int m_err  = 0;
  bit ignore_valid = 1'b0;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic       err;
    int         at;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] bw[$];
  logic [1:0] bc[$];

  rgmii_rx_framer #(.MAX_FRAME_BYTES(MAXB), .MIN_FRAME_BYTES(MINB)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .ddr_data_input    (ddr_data_input),
    .ddr_control_input (ddr_control_input),
    .data_output       (data_output),
    .data_valid        (data_valid),
    .data_last         (data_last),
    .data_error        (data_error),
    .frame_count       (frame_count),
    .error_count       (error_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] swapn(input logic [7:0] v);
    return {v[3:0], v[7:4]};
  endfunction

  function automatic bit is_er(input int idx);
    return bc[idx][1] ^ bc[idx][0];
  endfunction

  task automatic push_byte(input logic [7:0] logical, input logic [1:0] c);
    bw.push_back(swapn(logical));
    bc.push_back(c);
  endtask

  task automatic push_pre(input int n55);
    repeat (n55) push_byte(8'h55, 2'b11);
    push_byte(8'hD5, 2'b11);
  endtask

  task automatic push_payload(input int n, input int er_at);
    for (int k = 0; k < n; k++) push_byte(8'(k), (k == er_at) ? 2'b10 : 2'b11);
  endtask

  // Classify one whole burst (all rx_dv=1, followed by rx_dv=0) and queue its outputs.
  task automatic model_burst(input int base);
    int n, i, p, plen, nemit;
    bit bad;
    exp_t e;
    n = bw.size();
    i = 0;
    while (i < n && swapn(bw[i]) == 8'h55 && !is_er(i)) i++;
    if (i == n) begin
      m_err++;
    end else if (swapn(bw[i]) == 8'hD5 && !is_er(i)) begin
      p = i + 1;
      plen = n - p;
      if (plen == 0) begin
        m_err++;
      end else begin
        nemit = (plen > MAXB) ? MAXB : plen;
        bad = (plen > MAXB) || (plen < MINB);
        for (int k = 0; k < nemit; k++) if (is_er(p + k)) bad = 1'b1;
        for (int k = 0; k < nemit; k++) begin
          e.b    = swapn(bw[p + k]);
          e.last = (k == nemit - 1);
          e.err  = e.last & bad;
          e.at   = base + p + k + 2;
          expq.push_back(e);
        end
        if (bad) m_err++;
        else m_frm++;
      end
    end else begin
      m_err++;
    end
  endtask

  task automatic drive(input logic [7:0] w, input logic [1:0] c);
    ddr_data_input    = w;
    ddr_control_input = c;
    @(negedge clock);
  endtask

  task automatic drive_idle();
    drive(8'($urandom), {1'b0, 1'($urandom)});
  endtask

  task automatic run_burst(input int gap);
    int base;
    base = cyc + 1;
    model_burst(base);
    foreach (bw[k]) drive(bw[k], bc[k]);
    repeat (gap) drive_idle();
    check("frame_count", 32'(frame_count), 32'(m_frm));
    check("error_count", 32'(error_count), 32'(m_err));
    check("drained", 32'(expq.size()), 32'd0);
    bw.delete();
    bc.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(data_output), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_last"}, 32'(data_last), 32'd0);
    check({tag, "_error"}, 32'(data_error), 32'd0);
    check({tag, "_frames"}, 32'(frame_count), 32'd0);
    check({tag, "_errs"}, 32'(error_count), 32'd0);
  endtask

  // Output monitor: every data_valid pulse must match the next modelled byte and cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && data_valid) begin
      if (ignore_valid) begin
        check("abandoned_last", 32'(data_last), 32'd0);
      end else if (expq.size() == 0) begin
        check("unexpected_valid", 32'(data_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        check("byte", 32'(data_output), 32'(e.b));
        check("last", 32'(data_last), 32'(e.last));
        if (e.last) check("error", 32'(data_error), 32'(e.err));
        check("latency", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    int plen;
    int kind;
    reset_n           = 1'b0;
    ddr_data_input    = 8'h00;
    ddr_control_input = 2'b00;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (3) drive_idle();

    // Good 64-byte frame 0x00..0x3F
    push_pre(7); push_payload(64, -1); run_burst(6);
    // Nibble order: wire 0x21 must come out as 0x12
    push_pre(7);
    for (int k = 0; k < 64; k++) begin
      if (k == 5) begin bw.push_back(8'h21); bc.push_back(2'b11); end
      else push_byte(8'(k), 2'b11);
    end
    run_burst(6);
    // rx_er on byte 10
    push_pre(7); push_payload(64, 10); run_burst(6);
    // Runt, then zero-length
    push_pre(7); push_payload(20, -1); run_burst(6);
    push_pre(7); run_burst(6);
    // Oversize, then a normal frame
    push_pre(7); push_payload(150, -1); run_burst(6);
    push_pre(7); push_payload(70, -1); run_burst(6);
    // Length boundaries around MAX and MIN
    push_pre(7); push_payload(MAXB, -1); run_burst(6);
    push_pre(7); push_payload(MAXB + 1, -1); run_burst(6);
    push_pre(1); push_payload(MINB - 1, -1); run_burst(6);
    push_pre(0); push_payload(MINB, -1); run_burst(6);
    // Bad preamble
    push_byte(8'h55, 2'b11); push_byte(8'h55, 2'b11); push_byte(8'hAA, 2'b11);
    push_byte(8'hD5, 2'b11); push_byte(8'h34, 2'b11);
    run_burst(6);

    for (int r = 0; r < 30; r++) begin
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        repeat ($urandom_range(1, 6)) push_byte(8'($urandom), 2'b11);
      end else if (kind == 1) begin
        repeat ($urandom_range(1, 7)) push_byte(8'h55, 2'b11);
      end else if (kind == 2) begin
        repeat ($urandom_range(1, 5)) push_byte(8'h55, 2'b11);
        push_byte(8'h55, 2'b10);
      end else begin
        push_pre(int'($urandom_range(1, 7)));
        plen = int'($urandom_range(0, 110));
        for (int k = 0; k < plen; k++)
          push_byte(8'($urandom), ($urandom_range(0, 39) == 0) ? 2'b10 : 2'b11);
      end
      run_burst(int'($urandom_range(5, 9)));
    end

    // Reset in the middle of a payload: nothing may close the frame
    if (m_frm == 0) begin
      push_pre(7); push_payload(64, -1); run_burst(6);
    end
    push_pre(7); push_payload(30, -1);
    ignore_valid = 1'b1;
    for (int k = 0; k < 23; k++) drive(bw[k], bc[k]);
    reset_n = 1'b0;
    drive(bw[23], bc[23]);
    check_all_zero("midreset");
    reset_n = 1'b1;
    ignore_valid = 1'b0;
    m_frm = 0;
    m_err = 0;
    bw.delete();
    bc.delete();
    repeat (6) drive_idle();
    check("post_reset_frames", 32'(frame_count), 32'd0);
    check("post_reset_errs", 32'(error_count), 32'd0);
    push_pre(7); push_payload(64, -1); run_burst(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
